// File: rtl/rx_xgmii_pkg.sv
// Shared XGMII receive definitions: control characters, framer states and
// small byte-count/byte-mask helpers used by the framer.
package rx_xgmii_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] PREAMBLE    = 8'h55;
  localparam logic [7:0] SFD         = 8'hD5;

  localparam logic [63:0] START_BLOCK = {SFD, {6{PREAMBLE}}, XGMII_START};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // 11-bit byte counter add that sticks at 2047 instead of wrapping
  function automatic logic [10:0] cnt_add(input logic [10:0] cnt, input logic [3:0] inc);
    logic [11:0] sum;
    sum = {1'b0, cnt} + {8'h00, inc};
    cnt_add = sum[11] ? 11'h7FF : sum[10:0];
  endfunction

  function automatic logic [63:0] keep_bytes(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = (4'(i) < n) ? d[8*i +: 8] : 8'h00;
    end
    keep_bytes = r;
  endfunction

endpackage

// File: rtl/xgmii_term_decode.sv
// Combinational terminate decoder: finds a terminate in lane k with RXC[7:k]
// set and RXC[k-1:0] clear, and flags any other use of control lanes.
module xgmii_term_decode
  import rx_xgmii_pkg::*;
(
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic        term_found_o,
  output logic [2:0]  term_lane_o,
  output logic        ctrl_err_o
);

  logic       cand_s;
  logic [2:0] lane_s;

  // Only a contiguous upper run of control lanes can hold a terminate
  always_comb begin
    cand_s = 1'b1;
    lane_s = 3'd0;
    case (rxc_i)
      8'hFF: lane_s = 3'd0;
      8'hFE: lane_s = 3'd1;
      8'hFC: lane_s = 3'd2;
      8'hF8: lane_s = 3'd3;
      8'hF0: lane_s = 3'd4;
      8'hE0: lane_s = 3'd5;
      8'hC0: lane_s = 3'd6;
      8'h80: lane_s = 3'd7;
      default: cand_s = 1'b0;
    endcase
  end

  assign term_found_o = cand_s && (rxd_i[8*lane_s +: 8] == XGMII_TERM);
  assign term_lane_o  = lane_s;
  assign ctrl_err_o   = (rxc_i != 8'h00) && !term_found_o;

endmodule

// File: rtl/rx_xgmii_framer.sv
// XGMII receive framer: detects lane-0 start blocks, strips preamble/SFD and
// emits payload blocks with start/end/byte-count/error marking, 2-cycle latency.
module rx_xgmii_framer
  import rx_xgmii_pkg::*;
#(
  parameter int MAX_BYTES = 1522,
  parameter int MIN_BYTES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] XGMII_RXD,
  input  logic [7:0]  XGMII_RXC,
  output logic [63:0] PLS_DATA_IND,
  output logic        DATA_VALID,
  output logic        FRAME_START,
  output logic        FRAME_END,
  output logic [3:0]  END_BYTES,
  output logic        FRAME_ERR
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);
  localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);

  logic        term_found_s;
  logic [2:0]  term_lane_s;
  logic        ctrl_err_s;
  logic        is_start_s;
  logic        is_idle_s;
  logic        a_open_s;
  logic        mark_prev_s;
  logic        mark_err_s;
  logic [10:0] cnt_new_s;

  logic [1:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        sof_pend_q, sof_pend_d;

  logic [63:0] a_data_q, a_data_d;
  logic        a_dv_q, a_dv_d;
  logic        a_sof_q, a_sof_d;
  logic        a_eof_q, a_eof_d;
  logic        a_err_q, a_err_d;
  logic [3:0]  a_bytes_q, a_bytes_d;

  logic [63:0] o_data_q;
  logic        o_dv_q, o_sof_q, o_eof_q, o_err_q;
  logic [3:0]  o_bytes_q;

  xgmii_term_decode u_term_decode (
    .rxd_i        (XGMII_RXD),
    .rxc_i        (XGMII_RXC),
    .term_found_o (term_found_s),
    .term_lane_o  (term_lane_s),
    .ctrl_err_o   (ctrl_err_s)
  );

  assign is_start_s = (XGMII_RXC == 8'h01) && (XGMII_RXD == START_BLOCK);
  assign is_idle_s  = (XGMII_RXC == 8'hFF) && (XGMII_RXD[7:0] != XGMII_TERM);
  assign a_open_s   = a_dv_q && !a_eof_q;

  // Next state and stage-A contents; lane-0 terminates and aborts close the
  // block already in stage A, or insert an empty end marker if there is none.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sof_pend_d  = sof_pend_q;
    a_data_d    = 64'h0;
    a_dv_d      = 1'b0;
    a_sof_d     = 1'b0;
    a_eof_d     = 1'b0;
    a_err_d     = 1'b0;
    a_bytes_d   = 4'd0;
    mark_prev_s = 1'b0;
    mark_err_s  = 1'b0;
    cnt_new_s   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (is_start_s) begin
          state_d    = ST_DATA;
          cnt_d      = 11'd0;
          sof_pend_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (is_start_s) begin
          cnt_d      = 11'd0;
          sof_pend_d = 1'b1;
          if (a_open_s) begin
            mark_prev_s = 1'b1;
            mark_err_s  = 1'b1;
          end else begin
            a_eof_d = 1'b1;
            a_err_d = 1'b1;
          end
        end else if (term_found_s && (term_lane_s == 3'd0)) begin
          state_d    = ST_IDLE;
          sof_pend_d = 1'b0;
          if (a_open_s) begin
            mark_prev_s = 1'b1;
            mark_err_s  = (cnt_q < MIN_CNT);
          end else begin
            a_eof_d = 1'b1;
            a_err_d = 1'b1;
          end
        end else if (term_found_s) begin
          cnt_new_s  = cnt_add(cnt_q, {1'b0, term_lane_s});
          cnt_d      = cnt_new_s;
          a_dv_d     = 1'b1;
          a_data_d   = keep_bytes(XGMII_RXD, {1'b0, term_lane_s});
          a_sof_d    = sof_pend_q;
          a_eof_d    = 1'b1;
          a_bytes_d  = {1'b0, term_lane_s};
          a_err_d    = (cnt_new_s < MIN_CNT) || (cnt_new_s > MAX_CNT);
          sof_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_new_s  = cnt_add(cnt_q, 4'd8);
          cnt_d      = cnt_new_s;
          a_dv_d     = 1'b1;
          a_data_d   = XGMII_RXD;
          a_sof_d    = sof_pend_q;
          sof_pend_d = 1'b0;
          if (ctrl_err_s || (cnt_new_s > MAX_CNT)) begin
            a_eof_d   = 1'b1;
            a_err_d   = 1'b1;
            a_bytes_d = 4'd8;
            state_d   = ST_DROP;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DROP: begin
        if (term_found_s || is_idle_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, stage A and output register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 11'd0;
      sof_pend_q <= 1'b0;
      a_data_q   <= 64'h0;
      a_dv_q     <= 1'b0;
      a_sof_q    <= 1'b0;
      a_eof_q    <= 1'b0;
      a_err_q    <= 1'b0;
      a_bytes_q  <= 4'd0;
      o_data_q   <= 64'h0;
      o_dv_q     <= 1'b0;
      o_sof_q    <= 1'b0;
      o_eof_q    <= 1'b0;
      o_err_q    <= 1'b0;
      o_bytes_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sof_pend_q <= sof_pend_d;
      a_data_q   <= a_data_d;
      a_dv_q     <= a_dv_d;
      a_sof_q    <= a_sof_d;
      a_eof_q    <= a_eof_d;
      a_err_q    <= a_err_d;
      a_bytes_q  <= a_bytes_d;
      o_data_q   <= a_data_q;
      o_dv_q     <= a_dv_q;
      o_sof_q    <= a_sof_q;
      o_eof_q    <= a_eof_q | mark_prev_s;
      o_err_q    <= a_err_q | (mark_prev_s & mark_err_s);
      o_bytes_q  <= mark_prev_s ? 4'd8 : a_bytes_q;
    end
  end

  assign PLS_DATA_IND = o_data_q;
  assign DATA_VALID   = o_dv_q;
  assign FRAME_START  = o_sof_q;
  assign FRAME_END    = o_eof_q;
  assign END_BYTES    = o_bytes_q;
  assign FRAME_ERR    = o_err_q;

endmodule

// File: tb/tb_rx_xgmii_framer.sv
// Directed bench for rx_xgmii_framer: every cycle's outputs are captured by
// index, and each scenario checks the captured cycles 2 after its inputs.
module tb_rx_xgmii_framer;

  logic        CLK;
  logic        RST;
  logic [63:0] XGMII_RXD;
  logic [7:0]  XGMII_RXC;
  logic [63:0] PLS_DATA_IND;
  logic        DATA_VALID;
  logic        FRAME_START;
  logic        FRAME_END;
  logic [3:0]  END_BYTES;
  logic        FRAME_ERR;

  localparam logic [63:0] START = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] BADSF = 64'h5555_5555_5555_55FB;
  localparam logic [63:0] IDLEB = 64'h0707_0707_0707_0707;
  localparam logic [63:0] TERM0 = 64'h0707_0707_0707_07FD;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] cap_data [0:1023];
  logic        cap_dv   [0:1023];
  logic        cap_sof  [0:1023];
  logic        cap_eof  [0:1023];
  logic [3:0]  cap_nb   [0:1023];
  logic        cap_err  [0:1023];

  rx_xgmii_framer dut (
    .CLK          (CLK),
    .RST          (RST),
    .XGMII_RXD    (XGMII_RXD),
    .XGMII_RXC    (XGMII_RXC),
    .PLS_DATA_IND (PLS_DATA_IND),
    .DATA_VALID   (DATA_VALID),
    .FRAME_START  (FRAME_START),
    .FRAME_END    (FRAME_END),
    .END_BYTES    (END_BYTES),
    .FRAME_ERR    (FRAME_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [63:0] dblk(input int n);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'((n * 8 + j) & 255);
    return r;
  endfunction

  // data in lanes below k, terminate in lane k, idles above
  function automatic logic [63:0] tblk(input int k, input int n);
    logic [63:0] r;
    r = dblk(n);
    for (int j = 0; j < 8; j++) begin
      if (j == k) r[8*j +: 8] = 8'hFD;
      else if (j > k) r[8*j +: 8] = 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] tmask(input int k);
    logic [7:0] m;
    m = 8'hFF;
    return m << k;
  endfunction

  task automatic tick(input logic [63:0] d, input logic [7:0] c);
    @(negedge CLK);
    cap_data[cyc] = PLS_DATA_IND;
    cap_dv[cyc]   = DATA_VALID;
    cap_sof[cyc]  = FRAME_START;
    cap_eof[cyc]  = FRAME_END;
    cap_nb[cyc]   = END_BYTES;
    cap_err[cyc]  = FRAME_ERR;
    cyc++;
    XGMII_RXD = d;
    XGMII_RXC = c;
  endtask

  task automatic test_reset();
    int t;
    RST = 1'b1;
    XGMII_RXD = IDLEB;
    XGMII_RXC = 8'hFF;
    repeat (3) tick(IDLEB, 8'hFF);
    RST = 1'b0;
    repeat (2) tick(IDLEB, 8'hFF);
    t = cyc;
    tick(IDLEB, 8'hFF);
    checks++;
    if ({cap_data[t], cap_dv[t], cap_sof[t], cap_eof[t], cap_nb[t], cap_err[t]} !== 72'h0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h dv=%b sof=%b eof=%b nb=%0d err=%b expected all 0",
               cap_data[t], cap_dv[t], cap_sof[t], cap_eof[t], cap_nb[t], cap_err[t]);
    end
  endtask

  task automatic test_lane4_term();
    int t0, n;
    t0 = cyc;
    tick(START, 8'h01);
    for (int j = 1; j <= 8; j++) tick(dblk(j), 8'h00);
    tick(tblk(4, 9), 8'hF0);
    repeat (4) tick(IDLEB, 8'hFF);
    checks++;
    if (cap_dv[t0+2] !== 1'b0) begin failures++; $display("FAIL l4_start_stripped got dv=%b expected 0", cap_dv[t0+2]); end
    checks++;
    if ({cap_sof[t0+3], cap_dv[t0+3]} !== 2'b11 || cap_data[t0+3] !== dblk(1)) begin
      failures++; $display("FAIL l4_first got sof=%b dv=%b data=%h expected 1 1 %h", cap_sof[t0+3], cap_dv[t0+3], cap_data[t0+3], dblk(1));
    end
    n = 0;
    for (int i = t0 + 3; i <= t0 + 10; i++) if (cap_eof[i]) n++;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL l4_early_end got %0d ends expected 0", n); end
    checks++;
    if ({cap_eof[t0+11], cap_err[t0+11], cap_nb[t0+11]} !== {1'b1, 1'b0, 4'd4}) begin
      failures++; $display("FAIL l4_end got eof=%b err=%b nb=%0d expected 1 0 4", cap_eof[t0+11], cap_err[t0+11], cap_nb[t0+11]);
    end
    checks++;
    if (cap_data[t0+11] !== 64'h0000_0000_4B4A_4948) begin
      failures++; $display("FAIL l4_end_data got %h expected 000000004b4a4948", cap_data[t0+11]);
    end
    checks++;
    if (cap_dv[t0+12] !== 1'b0) begin failures++; $display("FAIL l4_after got dv=%b expected 0", cap_dv[t0+12]); end
  endtask

  task automatic test_lane0_term();
    int t0;
    t0 = cyc;
    tick(START, 8'h01);
    for (int j = 1; j <= 8; j++) tick(dblk(j + 16), 8'h00);
    tick(TERM0, 8'hFF);
    repeat (3) tick(IDLEB, 8'hFF);
    checks++;
    if ({cap_dv[t0+10], cap_eof[t0+10], cap_err[t0+10], cap_nb[t0+10]} !== {1'b1, 1'b1, 1'b0, 4'd8} || cap_data[t0+10] !== dblk(24)) begin
      failures++; $display("FAIL l0_end got dv=%b eof=%b err=%b nb=%0d data=%h expected 1 1 0 8 %h",
                           cap_dv[t0+10], cap_eof[t0+10], cap_err[t0+10], cap_nb[t0+10], cap_data[t0+10], dblk(24));
    end
    checks++;
    if ({cap_dv[t0+11], cap_eof[t0+11]} !== 2'b00) begin
      failures++; $display("FAIL l0_no_extra got dv=%b eof=%b expected 0 0", cap_dv[t0+11], cap_eof[t0+11]);
    end
    checks++;
    if (cap_eof[t0+9] !== 1'b0) begin failures++; $display("FAIL l0_prev_not_end got eof=%b expected 0", cap_eof[t0+9]); end
  endtask

  task automatic test_bad_sfd();
    int t0, n;
    t0 = cyc;
    tick(BADSF, 8'h01);
    for (int j = 1; j <= 4; j++) tick(dblk(j), 8'h00);
    tick(tblk(3, 5), 8'hF8);
    repeat (3) tick(IDLEB, 8'hFF);
    n = 0;
    for (int i = t0 + 1; i < cyc; i++) if (cap_dv[i] || cap_eof[i]) n++;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL bad_sfd got %0d active cycles expected 0", n); end
  endtask

  task automatic test_error_char();
    int t0, n;
    logic [63:0] eb;
    t0 = cyc;
    eb = dblk(4);
    eb[31:24] = 8'hFE;
    tick(START, 8'h01);
    for (int j = 1; j <= 3; j++) tick(dblk(j), 8'h00);
    tick(eb, 8'h08);
    tick(dblk(5), 8'h00);
    tick(dblk(6), 8'h00);
    tick(TERM0, 8'hFF);
    tick(IDLEB, 8'hFF);
    tick(START, 8'h01);
    for (int j = 1; j <= 8; j++) tick(dblk(j + 40), 8'h00);
    tick(TERM0, 8'hFF);
    repeat (3) tick(IDLEB, 8'hFF);
    checks++;
    if ({cap_dv[t0+6], cap_eof[t0+6], cap_err[t0+6]} !== 3'b111 || cap_data[t0+6] !== eb) begin
      failures++; $display("FAIL fe_block got dv=%b eof=%b err=%b data=%h expected 1 1 1 %h",
                           cap_dv[t0+6], cap_eof[t0+6], cap_err[t0+6], cap_data[t0+6], eb);
    end
    n = 0;
    for (int i = t0 + 7; i <= t0 + 11; i++) if (cap_dv[i] || cap_eof[i]) n++;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL fe_drop got %0d active cycles expected 0", n); end
    checks++;
    if ({cap_sof[t0+12], cap_dv[t0+12]} !== 2'b11 || cap_data[t0+12] !== dblk(41)) begin
      failures++; $display("FAIL fe_next_start got sof=%b dv=%b data=%h expected 1 1 %h", cap_sof[t0+12], cap_dv[t0+12], cap_data[t0+12], dblk(41));
    end
    checks++;
    if ({cap_eof[t0+19], cap_err[t0+19], cap_nb[t0+19]} !== {1'b1, 1'b0, 4'd8}) begin
      failures++; $display("FAIL fe_next_end got eof=%b err=%b nb=%0d expected 1 0 8", cap_eof[t0+19], cap_err[t0+19], cap_nb[t0+19]);
    end
  endtask

  task automatic test_runt();
    int t0;
    t0 = cyc;
    tick(START, 8'h01);
    tick(dblk(1), 8'h00);
    tick(dblk(2), 8'h00);
    tick(tblk(2, 3), tmask(2));
    repeat (3) tick(IDLEB, 8'hFF);
    checks++;
    if ({cap_sof[t0+3], cap_eof[t0+3]} !== 2'b10) begin
      failures++; $display("FAIL runt_first got sof=%b eof=%b expected 1 0", cap_sof[t0+3], cap_eof[t0+3]);
    end
    checks++;
    if ({cap_eof[t0+5], cap_err[t0+5], cap_nb[t0+5]} !== {1'b1, 1'b1, 4'd2} || cap_data[t0+5] !== 64'h0000_0000_0000_1918) begin
      failures++; $display("FAIL runt_end got eof=%b err=%b nb=%0d data=%h expected 1 1 2 0000000000001918",
                           cap_eof[t0+5], cap_err[t0+5], cap_nb[t0+5], cap_data[t0+5]);
    end
  endtask

  task automatic test_single_block();
    int t0;
    t0 = cyc;
    tick(START, 8'h01);
    tick(tblk(5, 7), tmask(5));
    repeat (3) tick(IDLEB, 8'hFF);
    checks++;
    if ({cap_dv[t0+3], cap_sof[t0+3], cap_eof[t0+3], cap_err[t0+3], cap_nb[t0+3]} !== {4'b1111, 4'd5}) begin
      failures++; $display("FAIL single got dv=%b sof=%b eof=%b err=%b nb=%0d expected 1 1 1 1 5",
                           cap_dv[t0+3], cap_sof[t0+3], cap_eof[t0+3], cap_err[t0+3], cap_nb[t0+3]);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    tick(START, 8'h01);
    for (int j = 1; j <= 3; j++) tick(dblk(j), 8'h00);
    tick(START, 8'h01);
    for (int j = 1; j <= 6; j++) tick(dblk(j + 60), 8'h00);
    tick(tblk(4, 70), tmask(4));
    repeat (3) tick(IDLEB, 8'hFF);
    checks++;
    if ({cap_dv[t0+5], cap_eof[t0+5], cap_err[t0+5]} !== 3'b111 || cap_data[t0+5] !== dblk(3)) begin
      failures++; $display("FAIL abort_end got dv=%b eof=%b err=%b data=%h expected 1 1 1 %h",
                           cap_dv[t0+5], cap_eof[t0+5], cap_err[t0+5], cap_data[t0+5], dblk(3));
    end
    checks++;
    if ({cap_dv[t0+6], cap_eof[t0+6], cap_sof[t0+7], cap_dv[t0+7]} !== 4'b0011 || cap_data[t0+7] !== dblk(61)) begin
      failures++; $display("FAIL abort_restart got dv6=%b eof6=%b sof7=%b dv7=%b data=%h expected 0 0 1 1 %h",
                           cap_dv[t0+6], cap_eof[t0+6], cap_sof[t0+7], cap_dv[t0+7], cap_data[t0+7], dblk(61));
    end
    checks++;
    if ({cap_eof[t0+13], cap_err[t0+13], cap_nb[t0+13]} !== {1'b1, 1'b1, 4'd4}) begin
      failures++; $display("FAIL abort_new_runt got eof=%b err=%b nb=%0d expected 1 1 4", cap_eof[t0+13], cap_err[t0+13], cap_nb[t0+13]);
    end
  endtask

  task automatic test_oversize();
    int t0, n, r;
    t0 = cyc;
    tick(START, 8'h01);
    for (int j = 1; j <= 200; j++) tick(dblk(j), 8'h00);
    tick(TERM0, 8'hFF);
    repeat (3) tick(IDLEB, 8'hFF);
    n = 0;
    for (int i = t0 + 3; i <= t0 + 192; i++) if (cap_eof[i]) n++;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL big_early_end got %0d ends expected 0", n); end
    checks++;
    if ({cap_dv[t0+193], cap_eof[t0+193], cap_err[t0+193]} !== 3'b111 || cap_data[t0+193] !== dblk(191)) begin
      failures++; $display("FAIL big_end got dv=%b eof=%b err=%b data=%h expected 1 1 1 %h",
                           cap_dv[t0+193], cap_eof[t0+193], cap_err[t0+193], cap_data[t0+193], dblk(191));
    end
    n = 0;
    for (int i = t0 + 194; i < cyc; i++) if (cap_dv[i] || cap_eof[i]) n++;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL big_drop got %0d active cycles expected 0", n); end

    tick(START, 8'h01);
    for (int j = 1; j <= 5; j++) tick(dblk(j), 8'h00);
    r = cyc;
    RST = 1'b1;
    tick(IDLEB, 8'hFF);
    RST = 1'b0;
    repeat (4) tick(IDLEB, 8'hFF);
    checks++;
    if (cap_dv[r-1] !== 1'b1) begin failures++; $display("FAIL rst_pre got dv=%b expected 1", cap_dv[r-1]); end
    checks++;
    if ({cap_data[r], cap_dv[r], cap_sof[r], cap_eof[r], cap_nb[r], cap_err[r]} !== 72'h0) begin
      failures++; $display("FAIL rst_mid got data=%h dv=%b sof=%b eof=%b nb=%0d err=%b expected all 0",
                           cap_data[r], cap_dv[r], cap_sof[r], cap_eof[r], cap_nb[r], cap_err[r]);
    end
    n = 0;
    for (int i = r + 1; i < cyc; i++) if (cap_dv[i] || cap_eof[i]) n++;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL rst_silent got %0d active cycles expected 0", n); end
  endtask

  initial begin
    RST = 1'b1;
    XGMII_RXD = IDLEB;
    XGMII_RXC = 8'hFF;
    test_reset();
    test_lane4_term();
    test_lane0_term();
    test_bad_sfd();
    test_error_char();
    test_runt();
    test_single_block();
    test_back_to_back();
    test_oversize();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_xgmii_framer.md
# rx_xgmii_framer

Receive-side framer between the 64-bit XGMII reconciliation-sublayer receive path and the destination-address check stage. It finds lane-0 start blocks, checks the preamble/SFD, and strips them. It then presents frame payload blocks on PLS_DATA_IND with FRAME_START aligned to the block carrying the DA. It also marks the last block with a valid-byte count and flags malformed, runt and oversize frames.

## Interface
- MAX_BYTES, 1522: largest legal frame in bytes, DA through FCS inclusive.
- MIN_BYTES, 64: smallest legal frame in bytes.
- CLK  input  1  rising-edge clock, XGMII receive domain.
- RST  input  1  synchronous, active-high reset.
- XGMII_RXD  input  64  receive data; lane n = bits [8n+7:8n]; lane 0 is first on the wire.
- XGMII_RXC  input  8  per-lane control flag; bit n qualifies lane n.
- PLS_DATA_IND  output  64  payload block, same lane order; bytes beyond END_BYTES are zero.
- DATA_VALID  output  1  PLS_DATA_IND carries frame bytes.
- FRAME_START  output  1  first payload block of a frame; DA is in bits [47:0].
- FRAME_END  output  1  last block of a frame, or of an aborted frame.
- END_BYTES  output  4  valid bytes (1..8) in the FRAME_END block; 0 otherwise.
- FRAME_ERR  output  1  qualifies FRAME_END: the frame is bad.

## Operation
- Start block: RXC=8'h01, lane0=8'hFB, lanes1–6=8'h55, lane7=8'hD5.
  - Any other lane0=FB with RXC[0]=1 is a bad start and is ignored, with no output.
  - A start in lane 4 is unsupported and ignored.
- States:
  - IDLE: wait for a valid start, then go to DATA.
  - DATA: every following block is payload.
    - Terminate (8'hFD) in lane k, with RXC[7:k] all 1 and RXC[k-1:0] all 0, ends the frame.
    - k=0: the previous block was last, with 8 bytes.
    - k=1..7: the current block is last, with k bytes. Go to IDLE.
  - DROP: discard blocks until any terminate or idle block (RXC=8'hFF, lane0≠FD), then go to IDLE.
- Errors in DATA. Each emits FRAME_END=1 and FRAME_ERR=1 on the offending output block, then enters DROP:
  - Any RXC bit set that does not form a valid terminate. This covers 8'hFE error characters and idles mid-frame.
  - Byte count exceeding MAX_BYTES.
  - Valid start block while in DATA:
    - Abort the current frame as an error.
    - Go directly to DATA for the new frame; no DROP.
    - If the abort falls on a block already emitted, emit an extra block with DATA_VALID=0, FRAME_END=1, FRAME_ERR=1, END_BYTES=0.
- Runt: a terminate that leaves the total below MIN_BYTES gives FRAME_ERR=1 with FRAME_END.
- Byte counter: 11 bits, saturating at 2047. Cleared on each start; incremented by 8 per data block or by k on terminate.
- Single-block frame (terminate in the first data block): FRAME_START, FRAME_END and FRAME_ERR (runt) all assert together.

## Timing
- Two register stages:
  - Stage A holds one block so a lane-0 terminate can mark its predecessor.
  - The output register drives every output.
- Fixed latency is 2 cycles from an input block to its output; no gaps and no backpressure.
- All control outputs are single-cycle per block.
- Reset:
  - All outputs 0, PLS_DATA_IND=64'h0, state IDLE, stage A empty, counter 0.
  - Reset mid-frame drops the frame silently; no FRAME_END is emitted.
- Downstream may decode PLS_DATA_IND combinationally in the FRAME_START cycle. Data and strobe come from the same register edge.

## Structure
- Shared package rx_xgmii_pkg holds:
  - Constants XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERROR=8'hFE, XGMII_IDLE=8'h07, PREAMBLE=8'h55, SFD=8'hD5.
  - The state encoding IDLE/DATA/DROP.
- One combinational sub-module, xgmii_term_decode: takes RXD/RXC, returns term_found, term_lane[2:0] and ctrl_err. It is reused by the transmit-side checker.

## Test plan
- Valid start, 8 data blocks, lane-4 terminate (68 bytes):
  - FRAME_START 2 cycles after the first data block.
  - FRAME_END on the 9th output block with END_BYTES=4 and FRAME_ERR=0.
  - Bytes 4–7 of that block are zero.
- Lane-0 terminate after 8 data blocks (64 bytes): FRAME_END lands on the 8th data block, END_BYTES=8, no empty output block.
- Start with lane7=8'h55 (bad SFD) followed by data: DATA_VALID stays 0 throughout.
- 8'hFE in lane 3 of the 4th data block:
  - That block is output with FRAME_END=1 and FRAME_ERR=1.
  - Later blocks are dropped until terminate, and the next valid frame is accepted.
- 3-block frame with a lane-2 terminate (18 bytes): FRAME_END, END_BYTES=2, FRAME_ERR=1 (runt).
- 200 data blocks (>1522 bytes): FRAME_ERR with FRAME_END on block 191, then nothing until the next start. Apply RST mid-frame and confirm all outputs are 0 the next cycle.
